// File: rtl/read_test_engine.sv
// read_test_engine: pattern generator feeding a wide FIFO that a host drains
// one OUT_WIDTH lane at a time.
//   clk, reset_n       : single clock, synchronous active-low reset
//   start/stop/clear   : control pulses (clear = flush, rewind, go idle)
//   mode               : 0 continuous, 1 counted (word_count lanes, rounded up)
//   pattern            : [1:0] select (counter/walking one/LFSR/constant), [31:2] seed
//   rd_en, dout        : host read strobe, lane data one cycle after rd_en
//   empty, almost_full, busy, done, underflow (sticky), clk_counts (run cycles)
// Optional build macro READ_TEST_ERR_INJECT_EN adds input inject_err, which flips
// bit 0 of lane 0 in the next written word.
module read_test_engine #(
   parameter int unsigned OUT_WIDTH  = 32,
   parameter int unsigned GEN_RATIO  = 2,
   parameter int unsigned FIFO_DEPTH = 1024,
   parameter int unsigned AF_MARGIN  = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 clear,
   input  logic                 mode,
   input  logic [31:0]          pattern,
   input  logic [31:0]          word_count,
`ifdef READ_TEST_ERR_INJECT_EN
   input  logic                 inject_err,
`endif
   input  logic                 rd_en,
   output logic [OUT_WIDTH-1:0] dout,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 busy,
   output logic                 done,
   output logic                 underflow,
   output logic [63:0]          clk_counts
);

   localparam int unsigned GW       = OUT_WIDTH * GEN_RATIO;
   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam int unsigned CW       = AW + 1;
   localparam int unsigned GR_LOG   = $clog2(GEN_RATIO);
   localparam int unsigned LW       = (GEN_RATIO > 1) ? GR_LOG : 1;
   localparam int unsigned AF_LEVEL = FIFO_DEPTH - AF_MARGIN;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          mem_q [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic [LW-1:0]          lane_q, lane_d;
   logic [OUT_WIDTH-1:0]   dout_q, dout_d;
   logic                   underflow_q, underflow_d;
   logic [63:0]            clk_counts_q, clk_counts_d;
   logic                   empty_q, empty_d;
   logic                   almost_full_q, almost_full_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   mode_q, mode_d;
   logic [32:0]            words_left_q, words_left_d;
   logic [1:0]             sel_q, sel_d;
   logic [OUT_WIDTH-1:0]   cnt_q, cnt_d, walk_q, walk_d, const_q, const_d;
   logic [31:0]            lfsr_q, lfsr_d;

   logic                   wr_en, pop;
   logic [GW-1:0]          gen_word, wr_word, rd_word;
   logic [OUT_WIDTH-1:0]   cnt_nxt, walk_nxt, c_tmp, w_tmp, lane_val;
   logic [31:0]            lfsr_nxt, l_tmp;

   // Fibonacci LFSR for x^32+x^22+x^2+x+1
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   function automatic logic [OUT_WIDTH-1:0] rotl1(input logic [OUT_WIDTH-1:0] v);
      return {v[OUT_WIDTH-2:0], v[OUT_WIDTH-1]};
   endfunction

   // Build one generated word; lane k is sequence element base+k
   always_comb begin
      gen_word = '0;
      c_tmp    = cnt_q;
      w_tmp    = walk_q;
      l_tmp    = lfsr_q;
      lane_val = '0;
      for (int k = 0; k < GEN_RATIO; k++) begin
         l_tmp = lfsr_step(l_tmp);
         case (sel_q)
            2'd0:    lane_val = c_tmp;
            2'd1:    lane_val = w_tmp;
            2'd2:    lane_val = OUT_WIDTH'(l_tmp);
            default: lane_val = const_q;
         endcase
         gen_word[k*OUT_WIDTH +: OUT_WIDTH] = lane_val;
         c_tmp = c_tmp + OUT_WIDTH'(1);
         w_tmp = rotl1(w_tmp);
      end
      cnt_nxt  = c_tmp;
      walk_nxt = w_tmp;
      lfsr_nxt = l_tmp;
   end

`ifdef READ_TEST_ERR_INJECT_EN
   logic inj_pend_q, inj_pend_d;

   // Hold an injection request until a word is actually written
   always_comb begin
      wr_word    = gen_word;
      inj_pend_d = inj_pend_q | inject_err;
      if (wr_en && inj_pend_d) begin
         wr_word[0] = ~gen_word[0];
         inj_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) inj_pend_q <= 1'b0;
      else          inj_pend_q <= inj_pend_d;
   end
`else
   assign wr_word = gen_word;
`endif

   assign rd_word = mem_q[rd_ptr_q];

   // Control, FIFO bookkeeping, read lane selection and next-state logic
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      lane_d       = lane_q;
      dout_d       = dout_q;
      underflow_d  = underflow_q;
      clk_counts_d = clk_counts_q;
      mode_d       = mode_q;
      words_left_d = words_left_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      walk_d       = walk_q;
      const_d      = const_q;
      lfsr_d       = lfsr_q;
      wr_en        = 1'b0;
      pop          = 1'b0;

      if (clear) begin
         state_d      = S_IDLE;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         lane_d       = '0;
         underflow_d  = 1'b0;
         clk_counts_d = '0;
      end else begin
         if (rd_en) begin
            if (empty_q) begin
               underflow_d = 1'b1;
            end else begin
               dout_d = rd_word[lane_q*OUT_WIDTH +: OUT_WIDTH];
               if (lane_q == LW'(GEN_RATIO - 1)) begin
                  pop      = 1'b1;
                  lane_d   = '0;
                  rd_ptr_d = rd_ptr_q + AW'(1);
               end else begin
                  lane_d = lane_q + LW'(1);
               end
            end
         end

         // almost_full throttles writes, so the FIFO can never overflow
         wr_en = (state_q == S_RUN) && !almost_full_q && (!mode_q || (words_left_q != 33'd0));
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_nxt;
            walk_d   = walk_nxt;
            lfsr_d   = lfsr_nxt;
            if (mode_q) words_left_d = words_left_q - 33'd1;
         end
         count_d = count_q + CW'(wr_en) - CW'(pop);

         if ((state_q == S_RUN) || (state_q == S_DRAIN)) clk_counts_d = clk_counts_q + 64'd1;

         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  clk_counts_d = '0;
                  mode_d       = mode;
                  words_left_d = (33'(word_count) + 33'(GEN_RATIO - 1)) >> GR_LOG;
                  sel_d        = pattern[1:0];
                  cnt_d        = OUT_WIDTH'(pattern[31:2]);
                  walk_d       = OUT_WIDTH'(1);
                  const_d      = OUT_WIDTH'({pattern[31:2], 2'b00});
                  lfsr_d       = (pattern[31:2] == 30'd0) ? 32'd1 : 32'(pattern[31:2]);
                  state_d      = (mode && (word_count == 32'd0)) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (stop)                                                  state_d = S_IDLE;
               else if (wr_en && mode_q && (words_left_q == 33'd1))       state_d = S_DRAIN;
            end
            S_DRAIN: begin
               if (stop)                                                  state_d = S_IDLE;
               else if ((pop && (count_q == CW'(1))) || empty_q)          state_d = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      empty_d       = (count_d == '0);
      almost_full_d = (count_d >= CW'(AF_LEVEL));
      busy_d        = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d        = (state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         lane_q        <= '0;
         dout_q        <= '0;
         underflow_q   <= 1'b0;
         clk_counts_q  <= '0;
         empty_q       <= 1'b1;
         almost_full_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         mode_q        <= 1'b0;
         words_left_q  <= '0;
         sel_q         <= '0;
         cnt_q         <= '0;
         walk_q        <= OUT_WIDTH'(1);
         const_q       <= '0;
         lfsr_q        <= 32'd1;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         lane_q        <= lane_d;
         dout_q        <= dout_d;
         underflow_q   <= underflow_d;
         clk_counts_q  <= clk_counts_d;
         empty_q       <= empty_d;
         almost_full_q <= almost_full_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         mode_q        <= mode_d;
         words_left_q  <= words_left_d;
         sel_q         <= sel_d;
         cnt_q         <= cnt_d;
         walk_q        <= walk_d;
         const_q       <= const_d;
         lfsr_q        <= lfsr_d;
      end
   end

   // FIFO storage, no reset needed
   always_ff @(posedge clk) begin
      if (reset_n && wr_en) mem_q[wr_ptr_q] <= wr_word;
   end

   assign dout        = dout_q;
   assign empty       = empty_q;
   assign almost_full = almost_full_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign underflow   = underflow_q;
   assign clk_counts  = clk_counts_q;

endmodule

// File: tb/tb_read_test_engine.sv
// Directed bench for read_test_engine (OUT_WIDTH=32, GEN_RATIO=2, FIFO_DEPTH=1024, AF_MARGIN=4).
module tb_read_test_engine;

   logic        clk, reset_n, start, stop, clear, mode, rd_en;
   logic [31:0] pattern, word_count;
   logic [31:0] dout;
   logic        empty, almost_full, busy, done, underflow;
   logic [63:0] clk_counts;
`ifdef READ_TEST_ERR_INJECT_EN
   logic        inject_err;
`endif

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] got_q[$];

   logic [31:0] pats     [7] = '{32'd0, 32'd0, 32'd400, 32'd1, 32'hABCD_1237, 32'd2, 32'd0};
   int          wcs      [7] = '{8, 5, 3, 4, 2, 4, 0};
   logic [31:0] exp_last [7] = '{32'd7, 32'd5, 32'd103, 32'd8, 32'hABCD_1234, 32'h0000_001B, 32'd0};

   read_test_engine #(
      .OUT_WIDTH (32),
      .GEN_RATIO (2),
      .FIFO_DEPTH(1024),
      .AF_MARGIN (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .stop       (stop),
      .clear      (clear),
      .mode       (mode),
      .pattern    (pattern),
      .word_count (word_count),
`ifdef READ_TEST_ERR_INJECT_EN
      .inject_err (inject_err),
`endif
      .rd_en      (rd_en),
      .dout       (dout),
      .empty      (empty),
      .almost_full(almost_full),
      .busy       (busy),
      .done       (done),
      .underflow  (underflow),
      .clk_counts (clk_counts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, want completion");
      $fatal(1, "watchdog expired");
   end

   // Reference sequence element s for a given pattern word
   function automatic logic [31:0] exp_elem(input logic [31:0] pat, input int s);
      logic [31:0] seed32, st;
      seed32 = {2'b00, pat[31:2]};
      case (pat[1:0])
         2'd0: exp_elem = seed32 + 32'(s);
         2'd1: exp_elem = 32'd1 << (s % 32);
         2'd2: begin
            st = (seed32 == 32'd0) ? 32'd1 : seed32;
            for (int i = 0; i <= s; i++) st = {st[30:0], st[31] ^ st[21] ^ st[1] ^ st[0]};
            exp_elem = st;
         end
         default: exp_elem = {pat[31:2], 2'b00};
      endcase
   endfunction

   // Counted run with host reads gated by empty; collects every delivered lane
   task automatic run_counted(input logic [31:0] pat, input logic [31:0] wc, output bit timed_out);
      int   cyc;
      logic pend;
      got_q.delete();
      pattern = pat; word_count = wc; mode = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (cyc < 400 && done !== 1'b1) begin
         rd_en = ~empty;
         pend  = ~empty;
         @(negedge clk);
         if (pend) got_q.push_back(dout);
         cyc++;
      end
      rd_en     = 1'b0;
      timed_out = (cyc >= 400);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (dout !== 32'd0)       begin miscompares++; $display("FAIL reset_dout: got %h want 0", dout); end
      vectors++; if (empty !== 1'b1)       begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
      vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_af: got %b want 0", almost_full); end
      vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0)        begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
      vectors++; if (underflow !== 1'b0)   begin miscompares++; $display("FAIL reset_uf: got %b want 0", underflow); end
      vectors++; if (clk_counts !== 64'd0) begin miscompares++; $display("FAIL reset_cc: got %0d want 0", clk_counts); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_patterns();
      bit to;
      int n;
      for (int i = 0; i < 7; i++) begin
         run_counted(pats[i], 32'(wcs[i]), to);
         n = (wcs[i] + 1) / 2 * 2;
         vectors++; if (to) begin miscompares++; $display("FAIL pat%0d_timeout: got no done want done", i); end
         vectors++; if (got_q.size() != n) begin miscompares++; $display("FAIL pat%0d_len: got %0d want %0d", i, got_q.size(), n); end
         for (int j = 0; j < got_q.size() && j < n; j++) begin
            vectors++;
            if (got_q[j] !== exp_elem(pats[i], j)) begin
               miscompares++; $display("FAIL pat%0d_elem%0d: got %h want %h", i, j, got_q[j], exp_elem(pats[i], j));
            end
         end
         if (n > 0) begin
            vectors++;
            if (dout !== exp_last[i]) begin miscompares++; $display("FAIL pat%0d_last: got %h want %h", i, dout, exp_last[i]); end
         end else begin
            vectors++;
            if (clk_counts !== 64'd0) begin miscompares++; $display("FAIL pat%0d_cc: got %0d want 0", i, clk_counts); end
         end
         vectors++; if (done !== 1'b1)      begin miscompares++; $display("FAIL pat%0d_done: got %b want 1", i, done); end
         vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL pat%0d_busy: got %b want 0", i, busy); end
         vectors++; if (empty !== 1'b1)     begin miscompares++; $display("FAIL pat%0d_empty: got %b want 1", i, empty); end
         vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL pat%0d_uf: got %b want 0", i, underflow); end
      end
   endtask

   task automatic test_lfsr_underflow();
      bit          to;
      logic [31:0] first, fourth;
      run_counted(32'd2, 32'd4, to);
      first  = (got_q.size() > 0) ? got_q[0] : 32'hx;
      fourth = (got_q.size() > 3) ? got_q[3] : 32'hx;
      vectors++; if (first !== 32'h0000_0003)  begin miscompares++; $display("FAIL lfsr_first: got %h want 00000003", first); end
      vectors++; if (fourth !== 32'h0000_001B) begin miscompares++; $display("FAIL lfsr_fourth: got %h want 0000001b", fourth); end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      vectors++; if (underflow !== 1'b1)     begin miscompares++; $display("FAIL uf_set: got %b want 1", underflow); end
      vectors++; if (dout !== 32'h0000_001B) begin miscompares++; $display("FAIL uf_dout_hold: got %h want 0000001b", dout); end
      @(negedge clk);
      vectors++; if (underflow !== 1'b1)     begin miscompares++; $display("FAIL uf_sticky: got %b want 1", underflow); end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      vectors++; if (underflow !== 1'b0)   begin miscompares++; $display("FAIL uf_clear: got %b want 0", underflow); end
      vectors++; if (done !== 1'b0)        begin miscompares++; $display("FAIL clear_done: got %b want 0", done); end
      vectors++; if (clk_counts !== 64'd0) begin miscompares++; $display("FAIL clear_cc: got %0d want 0", clk_counts); end
   endtask

   task automatic test_continuous_fill();
      int cyc, bad;
      pattern = 32'd0; mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (1100) @(negedge clk);
      vectors++; if (almost_full !== 1'b1) begin miscompares++; $display("FAIL fill_af: got %b want 1", almost_full); end
      vectors++; if (busy !== 1'b1)        begin miscompares++; $display("FAIL fill_busy: got %b want 1", busy); end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL stop_busy: got %b want 0", busy); end
      vectors++; if (almost_full !== 1'b1) begin miscompares++; $display("FAIL stop_retain: got %b want 1", almost_full); end
      got_q.delete();
      cyc = 0;
      while (empty !== 1'b1 && cyc < 4000) begin
         rd_en = 1'b1;
         @(negedge clk);
         got_q.push_back(dout);
         cyc++;
      end
      rd_en = 1'b0;
      vectors++; if (got_q.size() != 2040) begin miscompares++; $display("FAIL fill_len: got %0d want 2040", got_q.size()); end
      bad = 0;
      foreach (got_q[j]) if (got_q[j] !== 32'(j)) bad++;
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL fill_gapless: got %0d bad lanes want 0", bad); end
      vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL drained_af: got %b want 0", almost_full); end
   endtask

   task automatic test_continuous_stream();
      int   cyc, bad;
      logic pend;
      got_q.delete();
      pattern = 32'd0; mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (got_q.size() < 2048 && cyc < 5000) begin
         rd_en = ~empty;
         pend  = ~empty;
         @(negedge clk);
         if (pend) got_q.push_back(dout);
         cyc++;
      end
      rd_en = 1'b0;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stream_busy: got %b want 1", busy); end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      vectors++; if (got_q.size() != 2048) begin miscompares++; $display("FAIL stream_len: got %0d want 2048", got_q.size()); end
      bad = 0;
      foreach (got_q[j]) if (got_q[j] !== 32'(j)) bad++;
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL stream_gapless: got %0d bad lanes want 0", bad); end
   endtask

   task automatic test_clk_counts();
      mode = 1'b0; pattern = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      vectors++; if (clk_counts !== 64'd100) begin miscompares++; $display("FAIL cc_stop: got %0d want 100", clk_counts); end
      vectors++; if (busy !== 1'b0)          begin miscompares++; $display("FAIL cc_idle_busy: got %b want 0", busy); end
      repeat (10) @(negedge clk);
      vectors++; if (clk_counts !== 64'd100) begin miscompares++; $display("FAIL cc_frozen: got %0d want 100", clk_counts); end
      clear = 1'b1; start = 1'b1;
      @(negedge clk);
      clear = 1'b0; start = 1'b0;
      vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL clrstart_busy: got %b want 0", busy); end
      vectors++; if (clk_counts !== 64'd0) begin miscompares++; $display("FAIL clrstart_cc: got %0d want 0", clk_counts); end
      vectors++; if (empty !== 1'b1)       begin miscompares++; $display("FAIL clrstart_empty: got %b want 1", empty); end
      @(negedge clk);
      vectors++; if (clk_counts !== 64'd0) begin miscompares++; $display("FAIL clrstart_idle_cc: got %0d want 0", clk_counts); end
   endtask

   task automatic test_reset_mid_drain();
      pattern = 32'd0; word_count = 32'd64; mode = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL drain_busy: got %b want 1", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL drain_done: got %b want 0", done); end
      rd_en = 1'b1;
      repeat (3) @(negedge clk);
      rd_en = 1'b0;
      vectors++; if (dout !== 32'd2) begin miscompares++; $display("FAIL drain_dout: got %h want 2", dout); end
      vectors++; if (busy !== 1'b1)  begin miscompares++; $display("FAIL drain_still_busy: got %b want 1", busy); end
      reset_n = 1'b0; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      vectors++; if (dout !== 32'd0)       begin miscompares++; $display("FAIL mid_rst_dout: got %h want 0", dout); end
      vectors++; if (empty !== 1'b1)       begin miscompares++; $display("FAIL mid_rst_empty: got %b want 1", empty); end
      vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0)        begin miscompares++; $display("FAIL mid_rst_done: got %b want 0", done); end
      vectors++; if (underflow !== 1'b0)   begin miscompares++; $display("FAIL mid_rst_uf: got %b want 0", underflow); end
      vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL mid_rst_af: got %b want 0", almost_full); end
      vectors++; if (clk_counts !== 64'd0) begin miscompares++; $display("FAIL mid_rst_cc: got %0d want 0", clk_counts); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; mode = 1'b0; rd_en = 1'b0;
      pattern = 32'd0; word_count = 32'd0;
`ifdef READ_TEST_ERR_INJECT_EN
      inject_err = 1'b0;
`endif
      test_reset();
      test_patterns();
      test_lfsr_underflow();
      test_continuous_fill();
      test_continuous_stream();
      test_clk_counts();
      test_reset_mid_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/read_test_engine.md
READ_TEST_ENGINE -- requirements
Module: read_test_engine

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 32, meaning the host-side read word width in bits.
REQ-002 SHALL have parameter GEN_RATIO, default 2, meaning lanes per generated word; the generated word is OUT_WIDTH*GEN_RATIO bits; legal values 1, 2, 4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 1024, meaning the buffer depth in generated words; power of two, at least 16.
REQ-004 SHALL have parameter AF_MARGIN, default 4, meaning almost_full asserts when free entries <= AF_MARGIN.
REQ-005 SHALL have ports: clk in 1 (single clock, all logic on its rising edge); reset_n in 1 (synchronous, active-low).
REQ-006 SHALL have ports: start in 1 (pulse); stop in 1 (pulse); clear in 1 (pulse: flush and rewind); mode in 1 (0 continuous, 1 counted).
REQ-007 SHALL have ports: pattern in 32 (bits[1:0] pattern select, bits[31:2] seed/constant); word_count in 32 (OUT_WIDTH words to deliver in counted mode).
REQ-008 SHALL have ports: rd_en in 1 (host read strobe); dout out OUT_WIDTH; empty out 1; almost_full out 1; busy out 1; done out 1; underflow out 1 (sticky); clk_counts out 64.

Function
REQ-009 SHALL implement FSM IDLE, RUN, DRAIN, DONE; busy=1 in RUN or DRAIN; done=1 only in DONE.
REQ-010 SHALL, on start in IDLE or DONE: clear clk_counts, load generator from pattern, latch mode and word_count, enter RUN; start in RUN/DRAIN ignored.
REQ-011 SHALL increment clk_counts by 1 every cycle in RUN or DRAIN (first cycle after start reads 1); hold value in IDLE and DONE; wrap modulo 2^64.
REQ-012 SHALL write one generated word per cycle in RUN when almost_full=0; no write when almost_full=1 (no overflow possible).
REQ-013 SHALL generate lane k (k=0..GEN_RATIO-1) of generated word n from sequence element s=n*GEN_RATIO+k; lane 0 occupies bits [OUT_WIDTH-1:0] and is read first.
REQ-014 SHALL use patterns: 00 counter (element s = seed+s, truncated to OUT_WIDTH); 01 walking one (bit s mod OUT_WIDTH set); 10 LFSR x^32+x^22+x^2+x+1, one step per element, seed forced to 1 if zero; 11 constant {seed,2'b00} truncated.
REQ-015 SHALL, in counted mode, round word_count up to a multiple of GEN_RATIO, stop generating once that many lanes are written, then enter DRAIN; word_count=0 enters DONE the cycle after start with no data.
REQ-016 SHALL enter DONE from DRAIN in the cycle the last lane is consumed; clk_counts freezes including that cycle.
REQ-017 SHALL, in continuous mode, stay in RUN until stop; stop in RUN or DRAIN enters IDLE, freezes clk_counts, retains FIFO contents.
REQ-018 SHALL present the lane selected by rd_en on dout the cycle after rd_en (1-cycle registered latency); the lane pointer advances per read and pops the FIFO word after lane GEN_RATIO-1.
REQ-019 SHALL assert empty when no unread lane remains; rd_en while empty is ignored, dout holds, underflow sets until clear or reset.
REQ-020 SHALL accept write and read of the same FIFO entry-set in one cycle; a simultaneous write and pop on a full-minus-one FIFO keeps occupancy constant.
REQ-021 SHALL, on clear: flush FIFO, reset lane pointer, underflow, clk_counts, enter IDLE; clear has priority over start and stop in the same cycle.

Reset
REQ-022 SHALL, with reset_n=0 at a clk edge: state IDLE, FIFO empty, dout=0, clk_counts=0, underflow=0, busy=0, done=0, almost_full=0, empty=1; reset_n overrides all inputs including mid-transfer.

Configuration
REQ-023 SHALL, with macro READ_TEST_ERR_INJECT_EN defined, add input inject_err (1 bit): a pulse inverts bit 0 of lane 0 of the next written word only, sequence state unaffected.
REQ-024 SHALL, without READ_TEST_ERR_INJECT_EN, omit the inject_err port and produce unaltered data.

Verification
REQ-025 Counted, OUT_WIDTH=32, GEN_RATIO=2, pattern=0 seed 0, word_count=8, rd_en continuous -> dout 0..7 in order, done=1, underflow=0.
REQ-026 word_count=5, GEN_RATIO=2 -> 6 words delivered (0..5), then empty=1, DONE.
REQ-027 Continuous, no reads -> writes stop at FIFO_DEPTH-AF_MARGIN words, no loss; draining 2048 words returns a gapless counter.
REQ-028 LFSR seed 0 -> first element equals one LFSR step from 1; rd_en on empty -> underflow=1, dout unchanged.
REQ-029 Start, stop after 100 cycles -> clk_counts=100 frozen; clear with start same cycle -> IDLE, clk_counts=0.
REQ-030 reset_n=0 mid-DRAIN -> all REQ-022 values next cycle; with READ_TEST_ERR_INJECT_EN, inject_err -> exactly one word with bit 0 flipped.
